// File: rtl/memory_access_if.sv
// Data-bus handshake between the memory stage and data memory.
// Requests carry address/size/strobes; responses carry addr_ok/data_ok.
interface memory_access_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size,
    output dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size,
    input  dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_access.sv
// MIPS memory stage: issues data-bus requests, flags misalignment,
// and holds the raw load word plus pass-through fields for writeback.
module memory_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pcplus4,
  input  logic [31:0] in_aluout,
  input  logic [31:0] in_writedata,
  input  logic [31:0] in_hi,
  input  logic [31:0] in_lo,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        in_regwrite,
  input  logic [2:0]  in_mem_type,
  input  logic [4:0]  in_writereg,
  input  logic        flush,
  memory_access_if.master dbus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pcplus4,
  output logic [31:0] out_aluout,
  output logic [31:0] out_rd,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic        out_regwrite,
  output logic        out_memread,
  output logic [4:0]  out_writereg,
  output logic [2:0]  out_mem_type,
  output logic        out_exc_adel,
  output logic        out_exc_ades,
  output logic        stall
);
  localparam logic [2:0] MT_LB  = 3'd0;
  localparam logic [2:0] MT_LBU = 3'd1;
  localparam logic [2:0] MT_LH  = 3'd2;
  localparam logic [2:0] MT_LHU = 3'd3;
  localparam logic [2:0] MT_LW  = 3'd4;
  localparam logic [2:0] MT_SB  = 3'd5;
  localparam logic [2:0] MT_SH  = 3'd6;
  localparam logic [2:0] MT_SW  = 3'd7;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, FULL, DRAIN
  } state_t;

  state_t state, state_n;

  logic [1:0]  size;
  logic        misalign;
  logic        mem_op;
  logic        go;
  logic        acc;
  logic        capture;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_strobe;
  logic [31:0] r_data;

  always_comb begin
    size = 2'd2;
    unique case (in_mem_type)
      MT_LB, MT_LBU, MT_SB: size = 2'd0;
      MT_LH, MT_LHU, MT_SH: size = 2'd1;
      MT_LW, MT_SW:         size = 2'd2;
      default:              size = 2'd2;
    endcase
  end

  assign misalign = (size == 2'd1 && in_aluout[0])
                 || (size == 2'd2 && in_aluout[1:0] != 2'b00);
  assign mem_op = in_memread | in_memwrite;
  assign go     = mem_op & ~misalign;

  // Strobes and lane replication are fixed at accept so dreq_* stay stable.
  always_comb begin
    strobe = 4'b0000;
    wdata  = in_writedata;
    unique case (size)
      2'd0: begin
        strobe = 4'b0001 << in_aluout[1:0];
        wdata  = {4{in_writedata[7:0]}};
      end
      2'd1: begin
        strobe = in_aluout[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{in_writedata[15:0]}};
      end
      default: strobe = 4'b1111;
    endcase
    if (!in_memwrite) strobe = 4'b0000;
  end

  assign in_ready = (state == IDLE)
                 || (state == FULL && out_ready);
  assign acc = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (acc) state_n = go ? REQ : FULL;
      REQ:
        if (flush) begin
          if (dbus.dresp_addr_ok && !dbus.dresp_data_ok)
            state_n = DRAIN;
          else
            state_n = IDLE;
        end else if (dbus.dresp_addr_ok) begin
          state_n = dbus.dresp_data_ok ? FULL : WAIT;
        end
      WAIT:
        if (dbus.dresp_data_ok) state_n = flush ? IDLE : FULL;
        else if (flush)         state_n = DRAIN;
      FULL:
        if (flush)          state_n = IDLE;
        else if (out_ready) state_n = acc ? (go ? REQ : FULL) : IDLE;
      DRAIN:
        if (dbus.dresp_data_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign capture = ~flush & dbus.dresp_data_ok
                 & ((state == REQ && dbus.dresp_addr_ok)
                 || state == WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pcplus4  <= '0;
      out_aluout   <= '0;
      out_rd       <= '0;
      out_hi       <= '0;
      out_lo       <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_writereg <= '0;
      out_mem_type <= '0;
      out_exc_adel <= 1'b0;
      out_exc_ades <= 1'b0;
      r_size       <= '0;
      r_strobe     <= '0;
      r_data       <= '0;
    end else begin
      if (acc) begin
        out_pcplus4  <= in_pcplus4;
        out_aluout   <= in_aluout;
        out_rd       <= '0;
        out_hi       <= in_hi;
        out_lo       <= in_lo;
        out_regwrite <= in_regwrite & ~(mem_op & misalign);
        out_memread  <= in_memread;
        out_writereg <= in_writereg;
        out_mem_type <= in_mem_type;
        out_exc_adel <= in_memread & misalign;
        out_exc_ades <= in_memwrite & misalign;
        r_size       <= size;
        r_strobe     <= strobe;
        r_data       <= wdata;
      end
      if (capture) out_rd <= dbus.dresp_data;
    end
  end

  assign out_valid        = (state == FULL);
  assign stall            = (state == REQ) || (state == WAIT)
                         || (state == DRAIN);
  assign dbus.dreq_valid  = (state == REQ);
  assign dbus.dreq_addr   = out_aluout;
  assign dbus.dreq_size   = r_size;
  assign dbus.dreq_strobe = r_strobe;
  assign dbus.dreq_data   = r_data;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed vectors, a queue-based reference
// model, and a programmable-latency data-bus responder.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pcplus4 = '0, in_aluout = '0, in_writedata = '0;
  logic [31:0] in_hi = '0, in_lo = '0;
  logic        in_memread = 1'b0, in_memwrite = 1'b0, in_regwrite = 1'b0;
  logic [2:0]  in_mem_type = '0;
  logic [4:0]  in_writereg = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pcplus4, out_aluout, out_rd, out_hi, out_lo;
  logic        out_regwrite, out_memread;
  logic [4:0]  out_writereg;
  logic [2:0]  out_mem_type;
  logic        out_exc_adel, out_exc_ades;
  logic        stall;

  memory_access_if bus();

  memory_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pcplus4(in_pcplus4), .in_aluout(in_aluout),
    .in_writedata(in_writedata), .in_hi(in_hi), .in_lo(in_lo),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_regwrite(in_regwrite), .in_mem_type(in_mem_type),
    .in_writereg(in_writereg), .flush(flush), .dbus(bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pcplus4(out_pcplus4), .out_aluout(out_aluout),
    .out_rd(out_rd), .out_hi(out_hi), .out_lo(out_lo),
    .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_writereg(out_writereg), .out_mem_type(out_mem_type),
    .out_exc_adel(out_exc_adel), .out_exc_ades(out_exc_ades),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, alu, hi, lo, rd, data;
    logic [4:0]  wreg;
    logic [2:0]  mt;
    logic        mr, rw, adel, ades, req;
    logic [1:0]  size;
    logic [3:0]  strb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int addr_delay = 0;
  int data_delay = 0;
  logic [31:0] rdata = '0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes decides alignment, strobes, lanes.
  function automatic exp_t model(input logic mr, mw, rw,
      input logic [2:0] mt, input logic [31:0] pc, alu, wd, hi, lo,
      input logic [4:0] wreg, input logic [31:0] rdw);
    exp_t e;
    int nb;
    logic bad;
    case (mt)
      3'd0, 3'd1, 3'd5: nb = 1;
      3'd2, 3'd3, 3'd6: nb = 2;
      default:          nb = 4;
    endcase
    bad = (mr || mw) && (alu % nb != 0);
    e.pc = pc; e.alu = alu; e.hi = hi; e.lo = lo; e.rd = rdw;
    e.wreg = wreg; e.mt = mt; e.mr = mr;
    e.rw = rw && !bad;
    e.adel = bad && mr;
    e.ades = bad && mw;
    e.req = (mr || mw) && !bad;
    e.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
    e.strb = mw ? 4'(((1 << nb) - 1) << (alu % 4)) : 4'b0000;
    e.data = (nb == 1) ? wd[7:0] * 32'h0101_0101
           : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    return e;
  endfunction

  initial begin
    int acnt, dcnt;
    logic pend;
    acnt = 0; dcnt = 0; pend = 1'b0;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data = rdata;
      if (reset) pend = 1'b0;
      else if (pend) begin
        if (dcnt == 0) begin
          bus.dresp_data_ok = 1'b1;
          pend = 1'b0;
        end else dcnt--;
      end else if (bus.dreq_valid) begin
        if (acnt == 0) begin
          bus.dresp_addr_ok = 1'b1;
          acnt = addr_delay;
          if (data_delay == 0) bus.dresp_data_ok = 1'b1;
          else begin
            pend = 1'b1;
            dcnt = data_delay - 1;
          end
        end else acnt--;
      end else acnt = addr_delay;
    end
  end

  initial forever begin
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready)
        q.push_back(model(in_memread, in_memwrite, in_regwrite,
          in_mem_type, in_pcplus4, in_aluout, in_writedata,
          in_hi, in_lo, in_writereg, rdata));
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_unexpected", 32'(out_valid), 0);
        else begin
          e = q[0];
          chk("out_pcplus4", out_pcplus4, e.pc);
          chk("out_aluout", out_aluout, e.alu);
          chk("out_hi", out_hi, e.hi);
          chk("out_lo", out_lo, e.lo);
          chk("out_writereg", 32'(out_writereg), 32'(e.wreg));
          chk("out_mem_type", 32'(out_mem_type), 32'(e.mt));
          chk("out_memread", 32'(out_memread), 32'(e.mr));
          chk("out_regwrite", 32'(out_regwrite), 32'(e.rw));
          chk("out_exc_adel", 32'(out_exc_adel), 32'(e.adel));
          chk("out_exc_ades", 32'(out_exc_ades), 32'(e.ades));
          if (e.mr && e.req) chk("out_rd", out_rd, e.rd);
        end
      end
      if (bus.dreq_valid) begin
        if (q.size() == 0 || !q[0].req)
          chk("dreq_unexpected", 32'(bus.dreq_valid), 0);
        else begin
          e = q[0];
          chk("dreq_addr", bus.dreq_addr, e.alu);
          chk("dreq_size", 32'(bus.dreq_size), 32'(e.size));
          chk("dreq_strobe", 32'(bus.dreq_strobe), 32'(e.strb));
          chk("dreq_data", bus.dreq_data, e.data);
        end
      end
    end
  end

  int lat, stalls;
  logic seen_req, unstable;
  logic [31:0] l_addr, l_data;
  logic [3:0] l_strb;
  logic [1:0] l_size;

  task automatic issue(input logic mr, mw, rw, input logic [2:0] mt,
                       input logic [31:0] alu, wd, input logic [4:0] wr);
    int n;
    n = 0;
    @(negedge clk);
    pc_ctr = pc_ctr + 4;
    in_valid = 1'b1; in_memread = mr; in_memwrite = mw;
    in_regwrite = rw; in_mem_type = mt; in_aluout = alu;
    in_writedata = wd; in_writereg = wr; in_pcplus4 = pc_ctr;
    in_hi = ~alu; in_lo = alu ^ 32'h5A5A_5A5A;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 1);
    @(posedge clk);
  endtask

  task automatic wait_out();
    lat = 0; stalls = 0; seen_req = 1'b0; unstable = 1'b0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      stalls += int'(stall);
      if (bus.dreq_valid) begin
        if (seen_req && (l_addr !== bus.dreq_addr
            || l_data !== bus.dreq_data || l_strb !== bus.dreq_strobe
            || l_size !== bus.dreq_size))
          unstable = 1'b1;
        seen_req = 1'b1;
        l_addr = bus.dreq_addr; l_data = bus.dreq_data;
        l_strb = bus.dreq_strobe; l_size = bus.dreq_size;
      end
    end while (!out_valid && lat < 50);
    chk("out_valid_timeout", 32'(out_valid), 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dreq_valid", 32'(bus.dreq_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_regwrite", 32'(out_regwrite), 0);
    chk("rst_aluout", out_aluout, 0);
    chk("rst_rd", out_rd, 0);
    reset = 1'b0;

    issue(0, 0, 1, 3'd4, 32'h0000_1234, 0, 5'd8);
    wait_out();
    chk("alu_latency", lat, 1);
    chk("alu_aluout", out_aluout, 32'h0000_1234);
    chk("alu_writereg", 32'(out_writereg), 8);
    chk("alu_no_dreq", 32'(seen_req), 0);

    issue(0, 1, 0, 3'd5, 32'h8000_0003, 32'h0000_00AB, 5'd0);
    wait_out();
    chk("sb_strobe", 32'(l_strb), 32'h8);
    chk("sb_data", l_data, 32'hABAB_ABAB);
    chk("sb_size", 32'(l_size), 0);
    chk("sb_latency", lat, 2);

    issue(0, 1, 0, 3'd6, 32'h8000_0002, 32'h1234_5678, 5'd0);
    wait_out();
    chk("sh_strobe", 32'(l_strb), 32'hC);
    chk("sh_data", l_data, 32'h5678_5678);
    chk("sh_size", 32'(l_size), 1);

    addr_delay = 2; data_delay = 2; rdata = 32'hDEAD_BEEF;
    issue(1, 0, 1, 3'd4, 32'h8000_0010, 0, 5'd9);
    wait_out();
    chk("lw_stall_cycles", stalls, 5);
    chk("lw_rd", out_rd, 32'hDEAD_BEEF);
    chk("lw_dreq_stable", 32'(unstable), 0);
    chk("lw_strobe", 32'(l_strb), 0);
    addr_delay = 0; data_delay = 0;

    issue(1, 0, 1, 3'd2, 32'h8000_0001, 0, 5'd10);
    wait_out();
    chk("lh_mis_adel", 32'(out_exc_adel), 1);
    chk("lh_mis_regwrite", 32'(out_regwrite), 0);
    chk("lh_mis_no_dreq", 32'(seen_req), 0);
    chk("lh_mis_latency", lat, 1);

    issue(0, 1, 1, 3'd7, 32'h8000_0002, 32'h1111_2222, 5'd11);
    wait_out();
    chk("sw_mis_ades", 32'(out_exc_ades), 1);
    chk("sw_mis_adel", 32'(out_exc_adel), 0);
    chk("sw_mis_no_dreq", 32'(seen_req), 0);

    // Flush while WAIT; response arrives two cycles after the flush.
    data_delay = 3; rdata = 32'h0BAD_F00D;
    issue(1, 0, 1, 3'd4, 32'h8000_0020, 0, 5'd12);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!(stall && !bus.dreq_valid) && n < 20);
    chk("fl_reached_wait", 32'(stall && !bus.dreq_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_drain_stall", 32'(stall), 1);
    chk("fl_drain_out_valid", 32'(out_valid), 0);
    n = 1;
    while (!bus.dresp_data_ok && n < 20) begin
      chk("fl_hold_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      n++;
    end
    chk("fl_data_ok_gap", n, 2);
    chk("fl_stall_at_data_ok", 32'(stall), 1);
    @(negedge clk);
    chk("fl_stall_after", 32'(stall), 0);
    chk("fl_out_valid_after", 32'(out_valid), 0);
    data_delay = 0;
    issue(0, 0, 1, 3'd4, 32'h0000_0042, 0, 5'd13);
    wait_out();
    chk("fl_next_latency", lat, 1);
    chk("fl_next_aluout", out_aluout, 32'h0000_0042);

    // Back-to-back ALU ops with out_ready held high.
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      pc_ctr = pc_ctr + 4;
      in_valid = 1'b1; in_memread = 1'b0; in_memwrite = 1'b0;
      in_regwrite = 1'b1; in_mem_type = 3'd4;
      in_aluout = 32'h100 + 32'(i); in_writereg = 5'(20 + i);
      in_pcplus4 = pc_ctr; in_hi = ~in_aluout; in_lo = 32'(i);
      in_writedata = '0;
      @(negedge clk);
      n += int'(out_valid);
      if (i < 2) chk("tp_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    chk("tp_last_aluout", out_aluout, 32'h102);
    @(negedge clk);
    chk("tp_valid_count", n, 3);
    chk("tp_drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    issue(0, 0, 1, 3'd4, 32'h0000_0777, 0, 5'd5);
    wait_out();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_aluout", out_aluout, 32'h0000_0777);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(out_valid), 0);

    addr_delay = 5;
    issue(1, 0, 1, 3'd4, 32'h8000_0040, 0, 5'd6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_dreq_before", 32'(bus.dreq_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_dreq_valid", 32'(bus.dreq_valid), 0);
    chk("rm_stall", 32'(stall), 0);
    chk("rm_out_valid", 32'(out_valid), 0);
    chk("rm_aluout", out_aluout, 0);
    reset = 1'b0;
    addr_delay = 0;
    issue(0, 0, 1, 3'd4, 32'h0000_0099, 0, 5'd7);
    wait_out();
    chk("rm_next_latency", lat, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
